// File: rtl/tl_ul_req_buffer.sv
// -----------------------------------------------------------------------------
// tl_ul_req_buffer
//
// TL-UL A-channel request buffer with an outstanding-transaction limit. It sits
// between a TileLink host and its downstream TL-UL device. Requests are queued
// in a DEPTH-entry FIFO. The head entry is released downstream only while fewer
// than MAX_OUT requests are still waiting for a D-channel response. The block
// watches D-channel handshakes but does not buffer them.
//
// Optional feature (compile-time macro):
//   TL_UL_REQ_BUFFER_SOURCE_CHECK_EN
//     Adds a 2^AIW-bit in-flight bitmap. The head request stalls while its
//     source ID is still outstanding. A D response for a source that is not
//     in flight sets err_o.
//
// Parameters:
//   DW       data width (power of two, >= 32)
//   AW       address width
//   AIW      source ID width
//   SZW      size field width
//   DEPTH    FIFO entries (power of two, >= 2)
//   MAX_OUT  maximum outstanding downstream requests (1 .. 2^AIW)
//
// Ports:
//   clk_i, rst_i        clock; synchronous active-high reset
//   up_a_*              upstream A channel (valid/ready plus request fields)
//   dn_a_*              downstream A channel; fields show the FIFO head entry
//   d_valid_i/d_ready_i D-channel handshake, monitored only
//   d_source_i          D-channel source ID, monitored only
//   outstanding_o       number of requests waiting for a D response
//   err_o               sticky protocol error (D response with nothing owed)
// -----------------------------------------------------------------------------
module tl_ul_req_buffer #(
  parameter int unsigned DW      = 64,
  parameter int unsigned AW      = 32,
  parameter int unsigned AIW     = 4,
  parameter int unsigned SZW     = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,

  input  logic                         up_a_valid_i,
  output logic                         up_a_ready_o,
  input  logic [2:0]                   up_a_opcode_i,
  input  logic [SZW-1:0]               up_a_size_i,
  input  logic [AIW-1:0]               up_a_source_i,
  input  logic [AW-1:0]                up_a_address_i,
  input  logic [DW/8-1:0]              up_a_mask_i,
  input  logic [DW-1:0]                up_a_data_i,

  output logic                         dn_a_valid_o,
  input  logic                         dn_a_ready_i,
  output logic [2:0]                   dn_a_opcode_o,
  output logic [SZW-1:0]               dn_a_size_o,
  output logic [AIW-1:0]               dn_a_source_o,
  output logic [AW-1:0]                dn_a_address_o,
  output logic [DW/8-1:0]              dn_a_mask_o,
  output logic [DW-1:0]                dn_a_data_o,

  input  logic                         d_valid_i,
  input  logic                         d_ready_i,
  input  logic [AIW-1:0]               d_source_i,

  output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o,
  output logic                         err_o
);

  localparam int unsigned PW   = $clog2(DEPTH);      // FIFO index width
  localparam int unsigned PTRW = PW + 1;             // index plus wrap bit
  localparam int unsigned CW   = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic [2:0]      opcode;
    logic [SZW-1:0]  size;
    logic [AIW-1:0]  source;
    logic [AW-1:0]   address;
    logic [DW/8-1:0] mask;
    logic [DW-1:0]   data;
  } req_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  req_t            mem [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   outstanding_q;
  logic            err_q;

  logic            full, empty;
  logic            push, pop, d_hs;
  logic            below_limit, source_ok, src_err, underflow;
  req_t            head;
  req_t            wr_entry;

  // The pointers carry one extra wrap bit. Equal low bits with different
  // wrap bits means the writer is a full lap ahead of the reader.
  assign full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) &&
                 (wr_ptr_q[PW]     != rd_ptr_q[PW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign head = mem[rd_ptr_q[PW-1:0]];

  assign wr_entry = '{opcode:  up_a_opcode_i,
                      size:    up_a_size_i,
                      source:  up_a_source_i,
                      address: up_a_address_i,
                      mask:    up_a_mask_i,
                      data:    up_a_data_i};

  // A full FIFO refuses a push even when a pop frees a slot in the same
  // cycle. This keeps up_a_ready_o free of any path from dn_a_ready_i.
  assign up_a_ready_o = !full;
  assign push         = up_a_valid_i && !full;

  assign below_limit  = (outstanding_q < CW'(MAX_OUT));
  assign dn_a_valid_o = !empty && below_limit && source_ok;
  assign pop          = dn_a_valid_o && dn_a_ready_i;
  assign d_hs         = d_valid_i && d_ready_i;

  // The head fields come straight from storage. They stay stable until the
  // pop because a push can only write the head slot when the FIFO is empty.
  assign dn_a_opcode_o  = head.opcode;
  assign dn_a_size_o    = head.size;
  assign dn_a_source_o  = head.source;
  assign dn_a_address_o = head.address;
  assign dn_a_mask_o    = head.mask;
  assign dn_a_data_o    = head.data;

  // NOTE: storage has no reset. The pointers alone decide which entries are
  // valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q[PW-1:0]] <= wr_entry;
    end
  end

  // NOTE: sequential state is always written with non-blocking assignments,
  // so every reader in this clock domain sees the value from before the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding counter and sticky error
  // ---------------------------------------------------------------------------
  // A D response arriving when nothing is owed is an underflow. When a pop
  // happens in the same cycle, the two events cancel and the count holds.
  assign underflow = d_hs && !pop && (outstanding_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      unique case ({pop, d_hs})
        2'b10:   outstanding_q <= outstanding_q + CW'(1);
        2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - CW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (underflow || src_err) begin
      err_q <= 1'b1;
    end
  end

  assign outstanding_o = outstanding_q;
  assign err_o         = err_q;

  // ---------------------------------------------------------------------------
  // Optional per-source in-flight tracking
  // ---------------------------------------------------------------------------
`ifdef TL_UL_REQ_BUFFER_SOURCE_CHECK_EN
  localparam int unsigned NSRC = 1 << AIW;

  logic [NSRC-1:0] inflight_q;

  assign source_ok = !inflight_q[head.source];
  assign src_err   = d_hs && !inflight_q[d_source_i];

  // The clear is written before the set. When both hit the same bit, the
  // set from the pop wins. Different bits are both updated.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= '0;
    end else begin
      if (d_hs) inflight_q[d_source_i]  <= 1'b0;
      if (pop)  inflight_q[head.source] <= 1'b1;
    end
  end
`else
  logic unused_d_source;

  assign source_ok       = 1'b1;
  assign src_err         = 1'b0;
  assign unused_d_source = ^d_source_i;
`endif

endmodule

// File: tb/tb_tl_ul_req_buffer.sv
// -----------------------------------------------------------------------------
// tb_tl_ul_req_buffer
//
// Directed self-checking bench for tl_ul_req_buffer with default parameters
// (DW=64, AW=32, AIW=4, SZW=2, DEPTH=4, MAX_OUT=2). Expected values are hand
// computed. Inputs change and outputs are sampled 2 ns after each rising edge.
// The source-check scenario follows TL_UL_REQ_BUFFER_SOURCE_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_tl_ul_req_buffer;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int AIW = 4;
  localparam int SZW = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            up_a_valid_i;
  logic            up_a_ready_o;
  logic [2:0]      up_a_opcode_i;
  logic [SZW-1:0]  up_a_size_i;
  logic [AIW-1:0]  up_a_source_i;
  logic [AW-1:0]   up_a_address_i;
  logic [DW/8-1:0] up_a_mask_i;
  logic [DW-1:0]   up_a_data_i;
  logic            dn_a_valid_o;
  logic            dn_a_ready_i;
  logic [2:0]      dn_a_opcode_o;
  logic [SZW-1:0]  dn_a_size_o;
  logic [AIW-1:0]  dn_a_source_o;
  logic [AW-1:0]   dn_a_address_o;
  logic [DW/8-1:0] dn_a_mask_o;
  logic [DW-1:0]   dn_a_data_o;
  logic            d_valid_i;
  logic            d_ready_i;
  logic [AIW-1:0]  d_source_i;
  logic [1:0]      outstanding_o;
  logic            err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  tl_ul_req_buffer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .up_a_valid_i   (up_a_valid_i),
    .up_a_ready_o   (up_a_ready_o),
    .up_a_opcode_i  (up_a_opcode_i),
    .up_a_size_i    (up_a_size_i),
    .up_a_source_i  (up_a_source_i),
    .up_a_address_i (up_a_address_i),
    .up_a_mask_i    (up_a_mask_i),
    .up_a_data_i    (up_a_data_i),
    .dn_a_valid_o   (dn_a_valid_o),
    .dn_a_ready_i   (dn_a_ready_i),
    .dn_a_opcode_o  (dn_a_opcode_o),
    .dn_a_size_o    (dn_a_size_o),
    .dn_a_source_o  (dn_a_source_o),
    .dn_a_address_o (dn_a_address_o),
    .dn_a_mask_o    (dn_a_mask_o),
    .dn_a_data_o    (dn_a_data_o),
    .d_valid_i      (d_valid_i),
    .d_ready_i      (d_ready_i),
    .d_source_i     (d_source_i),
    .outstanding_o  (outstanding_o),
    .err_o          (err_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Drive an upstream request. The data field is derived from the address so
  // the head data can be checked too.
  task automatic drive_a(input logic v, input logic [AIW-1:0] src, input logic [AW-1:0] addr);
    up_a_valid_i   = v;
    up_a_opcode_i  = 3'd4;
    up_a_size_i    = 2'd2;
    up_a_source_i  = src;
    up_a_address_i = addr;
    up_a_mask_i    = 8'h0f;
    up_a_data_i    = {32'hcafe0000, addr};
  endtask

  task automatic drive_d(input logic v, input logic [AIW-1:0] src);
    d_valid_i  = v;
    d_ready_i  = v;
    d_source_i = src;
  endtask

  initial begin
    rst_i        = 1'b1;
    dn_a_ready_i = 1'b0;
    drive_a(1'b0, 4'd0, 32'h0);
    drive_d(1'b0, 4'd0);
    tick();
    tick();
    rst_i = 1'b0;

    // Reset state
    check("rst_up_ready", up_a_ready_o, 1);
    check("rst_dn_valid", dn_a_valid_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_err", err_o, 0);

    // Single request: source 3, address 0x1000
    drive_a(1'b1, 4'd3, 32'h1000);
    tick();
    drive_a(1'b0, 4'd0, 32'h0);
    check("t1_dn_valid", dn_a_valid_o, 1);
    check("t1_source", dn_a_source_o, 3);
    check("t1_address", dn_a_address_o, 32'h1000);
    check("t1_opcode", dn_a_opcode_o, 4);
    check("t1_size", dn_a_size_o, 2);
    check("t1_mask", dn_a_mask_o, 8'h0f);
    check("t1_data", dn_a_data_o, 64'hcafe0000_00001000);
    dn_a_ready_i = 1'b1;
    tick();
    dn_a_ready_i = 1'b0;
    check("t1_outstanding", outstanding_o, 1);
    check("t1_empty", dn_a_valid_o, 0);
    drive_d(1'b1, 4'd3);
    tick();
    drive_d(1'b0, 4'd0);
    check("t1_resp_outstanding", outstanding_o, 0);
    check("t1_err", err_o, 0);

    // Fill: 5 back-to-back pushes, the fifth is refused
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, 4'(i), 32'h2000 + 32'(i * 4));
      check($sformatf("t2_up_ready_%0d", i), up_a_ready_o, (i < 4) ? 1 : 0);
      tick();
    end
    drive_a(1'b0, 4'd0, 32'h0);
    check("t2_full", up_a_ready_o, 0);
    // Drain in FIFO order, answering each request before the next pop
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_dn_valid_%0d", i), dn_a_valid_o, 1);
      check($sformatf("t2_addr_%0d", i), dn_a_address_o, 32'h2000 + 32'(i * 4));
      check($sformatf("t2_src_%0d", i), dn_a_source_o, i);
      dn_a_ready_i = 1'b1;
      tick();
      dn_a_ready_i = 1'b0;
      if (i == 0) check("t2_up_ready_after_pop", up_a_ready_o, 1);
      check($sformatf("t2_out_%0d", i), outstanding_o, 1);
      drive_d(1'b1, 4'(i));
      tick();
      drive_d(1'b0, 4'd0);
    end
    check("t2_drained", dn_a_valid_o, 0);
    check("t2_err", err_o, 0);

    // Outstanding limit: queue 3, allow only 2 pops
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 4'(i), 32'h3000 + 32'(i * 4));
      tick();
    end
    drive_a(1'b0, 4'd0, 32'h0);
    dn_a_ready_i = 1'b1;
    tick();
    tick();
    check("t3_out_limit", outstanding_o, 2);
    check("t3_valid_blocked", dn_a_valid_o, 0);
    tick();
    check("t3_still_blocked", dn_a_valid_o, 0);
    check("t3_still_out", outstanding_o, 2);
    drive_d(1'b1, 4'd0);
    tick();
    drive_d(1'b0, 4'd0);
    check("t3_reenabled", dn_a_valid_o, 1);
    check("t3_third_addr", dn_a_address_o, 32'h3008);
    check("t3_out_after_resp", outstanding_o, 1);
    tick();
    dn_a_ready_i = 1'b0;
    check("t3_out_third", outstanding_o, 2);
    check("t3_empty", dn_a_valid_o, 0);

    // Simultaneous pop and response at count 1, then underflow
    drive_d(1'b1, 4'd1);
    tick();
    drive_d(1'b0, 4'd0);
    check("t4_out_one", outstanding_o, 1);
    drive_a(1'b1, 4'd4, 32'h4000);
    tick();
    drive_a(1'b0, 4'd0, 32'h0);
    check("t4_head_valid", dn_a_valid_o, 1);
    dn_a_ready_i = 1'b1;
    drive_d(1'b1, 4'd2);
    tick();
    dn_a_ready_i = 1'b0;
    drive_d(1'b0, 4'd0);
    check("t4_pop_and_resp", outstanding_o, 1);
    check("t4_no_err", err_o, 0);
    drive_d(1'b1, 4'd4);
    tick();
    drive_d(1'b0, 4'd0);
    check("t4_out_zero", outstanding_o, 0);
    check("t4_no_err_yet", err_o, 0);
    drive_d(1'b1, 4'd7);
    tick();
    drive_d(1'b0, 4'd0);
    check("t4_underflow_err", err_o, 1);
    check("t4_underflow_count", outstanding_o, 0);
    tick();
    tick();
    check("t4_err_sticky", err_o, 1);

    // Reset mid-operation: 2 outstanding, 3 queued
    dn_a_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, 4'(8 + i), 32'h6000 + 32'(i * 4));
      tick();
    end
    drive_a(1'b0, 4'd0, 32'h0);
    dn_a_ready_i = 1'b0;
    check("t6_pre_out", outstanding_o, 2);
    check("t6_pre_head", dn_a_address_o, 32'h6008);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t6_dn_valid", dn_a_valid_o, 0);
    check("t6_outstanding", outstanding_o, 0);
    check("t6_up_ready", up_a_ready_o, 1);
    check("t6_err_cleared", err_o, 0);

    // Two requests with the same source ID 5
    drive_a(1'b1, 4'd5, 32'h5000);
    tick();
    drive_a(1'b1, 4'd5, 32'h5004);
    tick();
    drive_a(1'b0, 4'd0, 32'h0);
    dn_a_ready_i = 1'b1;
    tick();
    check("t5_first_popped", outstanding_o, 1);
`ifdef TL_UL_REQ_BUFFER_SOURCE_CHECK_EN
    check("t5_second_stalls", dn_a_valid_o, 0);
    tick();
    check("t5_still_stalled", dn_a_valid_o, 0);
    check("t5_still_out", outstanding_o, 1);
    drive_d(1'b1, 4'd5);
    tick();
    drive_d(1'b0, 4'd0);
    check("t5_released", dn_a_valid_o, 1);
    check("t5_second_addr", dn_a_address_o, 32'h5004);
    tick();
    dn_a_ready_i = 1'b0;
    check("t5_second_popped", outstanding_o, 1);
    check("t5_no_err", err_o, 0);
    drive_d(1'b1, 4'd7);
    tick();
    drive_d(1'b0, 4'd0);
    check("t5_idle_source_err", err_o, 1);
`else
    check("t5_second_valid", dn_a_valid_o, 1);
    check("t5_second_addr", dn_a_address_o, 32'h5004);
    tick();
    dn_a_ready_i = 1'b0;
    check("t5_both_popped", outstanding_o, 2);
    drive_d(1'b1, 4'd7);
    tick();
    drive_d(1'b0, 4'd0);
    check("t5_any_source_ok", err_o, 0);
    check("t5_out_after_resp", outstanding_o, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_ul_req_buffer.md
# tl_ul_req_buffer

Parametrised TL-UL A-channel request buffer with outstanding-transaction limiting, placed between a TileLink host (e.g. the SRoT or an LLKI-enabled core wrapper) and its downstream TL-UL device. Its widths are set per instance rather than fixed in a package, so one block serves buses of any width. Requests are queued in a DEPTH-entry FIFO and released downstream only while fewer than MAX_OUT transactions are awaiting a D-channel response. The block observes, but does not buffer, D-channel handshakes.

## Interface
- DW, 64: data width; power of two, ≥ 32.
- AW, 32: address width.
- AIW, 4: source ID width.
- SZW, 2: size field width.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- MAX_OUT, 2: maximum outstanding downstream requests; 1..2^AIW.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- up_a_valid_i  in  1  upstream request valid.
- up_a_ready_o  out  1  upstream request accepted.
- up_a_opcode_i  in  3  TL opcode.
- up_a_size_i  in  SZW  log2 byte size.
- up_a_source_i  in  AIW  source ID.
- up_a_address_i  in  AW  address.
- up_a_mask_i  in  DW/8  byte mask.
- up_a_data_i  in  DW  write data.
- dn_a_valid_o  out  1  downstream request valid.
- dn_a_ready_i  in  1  downstream request accepted.
- dn_a_opcode_o, dn_a_size_o, dn_a_source_o, dn_a_address_o, dn_a_mask_o, dn_a_data_o  out  as upstream  head-entry fields.
- d_valid_i  in  1  D-channel response valid (monitored).
- d_ready_i  in  1  D-channel response ready (monitored).
- d_source_i  in  AIW  D-channel response source ID.
- outstanding_o  out  $clog2(MAX_OUT+1)  current outstanding count.
- err_o  out  1  sticky protocol-error flag.

## Operation
- Upstream push: up_a_valid_i && up_a_ready_o. up_a_ready_o = !full. No push when full, even if a pop occurs the same cycle.
- Downstream pop: dn_a_valid_o && dn_a_ready_i. dn_a_valid_o = !empty && (outstanding < MAX_OUT) && source_ok. source_ok is 1 unless SOURCE_CHECK is compiled in.
- dn_a_* fields show the head entry combinationally from storage. They hold steady while dn_a_valid_o is high and not accepted.
- FIFO: write and read pointers of $clog2(DEPTH)+1 bits. Full when the low bits are equal and the MSBs differ; empty when all bits are equal. Pointers wrap modulo 2·DEPTH.
- Outstanding counter: +1 on a downstream pop; −1 on a D handshake (d_valid_i && d_ready_i); unchanged when both occur together.
- D handshake while the count is 0: the count stays 0 and err_o is set.
- err_o stays high until reset.

## Timing
- Reset values: pointers 0, outstanding_o 0, err_o 0, up_a_ready_o 1, dn_a_valid_o 0. FIFO storage is not reset.
- Latency: a request pushed at edge N is presented on dn_a_* after edge N (earliest pop at edge N+1). There is no empty-FIFO bypass.
- Throughput: one push and one pop per cycle when not full and not limited.
- A pop that takes the count to MAX_OUT deasserts dn_a_valid_o from the next cycle. A D handshake at count MAX_OUT re-enables dn_a_valid_o from the next cycle.
- Reset asserted mid-operation: all queued and outstanding state is discarded within the same edge.

## Configuration
- TL_UL_REQ_BUFFER_SOURCE_CHECK_EN defined:
  - Adds a 2^AIW-bit in-flight bitmap.
  - A pop sets the bit for dn_a_source_o; a D handshake clears the bit for d_source_i.
  - source_ok = !inflight[head source], so the head stalls while its source ID is outstanding.
  - A D handshake whose source bit is already clear sets err_o.
  - A set and clear of different bits in the same cycle both take effect.
- Undefined: no bitmap, source_ok = 1, and err_o is set only by counter underflow.

## Test plan
- Reset, then push 1 request (source 3, addr 0x1000): up_a_ready_o=1; dn_a_valid_o=1 the cycle after the push with fields matching; outstanding_o=1 after the pop.
- DEPTH=4, dn_a_ready_i=0, push 5 back-to-back: 4 accepted, up_a_ready_o=0 on the 5th; drain shows FIFO order, and up_a_ready_o rises the cycle after the first pop.
- MAX_OUT=2, 3 queued, no D responses: exactly 2 pops, then dn_a_valid_o=0. One D handshake: the 3rd pops the next cycle with outstanding_o=2.
- Pop and D handshake in the same cycle at count 1: count stays 1. A D handshake at count 0: err_o=1, and it persists until rst_i.
- With TL_UL_REQ_BUFFER_SOURCE_CHECK_EN, two requests with source 5: the second stalls until d_source_i=5 handshakes. A D response for idle source 7 sets err_o.
- Assert rst_i with 3 queued and 2 outstanding: the next cycle dn_a_valid_o=0, outstanding_o=0, up_a_ready_o=1.
